// File: rtl/spi_flash_cmd_engine_if.sv
// Command-side bus between the APB flash bridge and the SPI command engine.
// The bridge drives requests; the engine returns busy/done and read bytes.
interface spi_flash_cmd_engine_if;
  logic [4:0]  cmd_type;
  logic [7:0]  cmd_code;
  logic [23:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_busy;
  logic        cmd_done;
  logic [7:0]  cmd_rdata;
  logic        cmd_rvalid;

  modport master (
    output cmd_type, cmd_code, cmd_addr, cmd_wdata,
    input  cmd_busy, cmd_done, cmd_rdata, cmd_rvalid
  );

  modport slave (
    input  cmd_type, cmd_code, cmd_addr, cmd_wdata,
    output cmd_busy, cmd_done, cmd_rdata, cmd_rvalid
  );
endinterface

// File: rtl/spi_flash_cmd_engine.sv
// Serialises one flash command per request onto SPI mode-0 pins (sck = spi_clk/2),
// MSB-first, returning read bytes and an end-of-frame pulse.
module spi_flash_cmd_engine #(
  parameter int RD_BYTES    = 4,
  parameter int WR_BYTES    = 4,
  parameter int CS_HIGH_CYC = 4
) (
  input  logic                    spi_clk,
  input  logic                    spi_resetn,
  spi_flash_cmd_engine_if.slave   cmd,
  output logic                    flash_cs_n,
  output logic                    flash_sck,
  output logic                    flash_mosi,
  input  logic                    flash_miso
);

  localparam int          GAP_W    = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_HIGH_CYC - 1);
  localparam logic [6:0]  RD_BITS  = 7'(8 * RD_BYTES);
  localparam logic [6:0]  WR_BITS  = 7'(8 * WR_BYTES);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP} state_t;

  state_t           state_r;
  logic             frame_valid_r;
  logic [63:0]      tx_sr_r;
  logic [6:0]       tx_bits_r;
  logic [6:0]       total_bits_r;
  logic [6:0]       bit_cnt_r;
  logic [6:0]       rx_sr_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             cs_n_r, sck_r, mosi_r;
  logic             busy_r, done_r, rvalid_r;
  logic [7:0]       rdata_r;

  logic             dec_valid_s;
  logic [63:0]      dec_frame_s;
  logic [6:0]       dec_tx_bits_s;
  logic [6:0]       dec_total_s;
  logic [31:0]      wr_seq_s;

  // Frame image (left-aligned, zero padded) and bit counts for the offered command
  always_comb begin
    wr_seq_s      = {cmd.cmd_wdata[7:0], cmd.cmd_wdata[15:8],
                     cmd.cmd_wdata[23:16], cmd.cmd_wdata[31:24]};
    dec_valid_s   = 1'b1;
    dec_frame_s   = {cmd.cmd_code, 56'd0};
    dec_tx_bits_s = 7'd8;
    dec_total_s   = 7'd8;
    case (cmd.cmd_type)
      5'b10000: dec_total_s = 7'd32;
      5'b10001, 5'b10100: dec_total_s = 7'd8;
      5'b10010: begin
        dec_frame_s   = {cmd.cmd_code, cmd.cmd_addr, 32'd0};
        dec_tx_bits_s = 7'd32;
        dec_total_s   = 7'd32;
      end
      5'b10011: dec_total_s = 7'd16;
      5'b10101: begin
        dec_frame_s   = {cmd.cmd_code, cmd.cmd_addr, wr_seq_s};
        dec_tx_bits_s = 7'd32 + WR_BITS;
        dec_total_s   = 7'd32 + WR_BITS;
      end
      5'b10111: begin
        dec_frame_s   = {cmd.cmd_code, cmd.cmd_addr, 32'd0};
        dec_tx_bits_s = 7'd32;
        dec_total_s   = 7'd32 + RD_BITS;
      end
      default: dec_valid_s = 1'b0;
    endcase
  end

  // Frame sequencer: sck phase, shift/sample on the falling phase, CS gap timing
  always_ff @(posedge spi_clk) begin
    if (!spi_resetn) begin
      state_r       <= IDLE;
      frame_valid_r <= 1'b0;
      tx_sr_r       <= 64'd0;
      tx_bits_r     <= 7'd0;
      total_bits_r  <= 7'd0;
      bit_cnt_r     <= 7'd0;
      rx_sr_r       <= 7'd0;
      gap_cnt_r     <= GAP_W'(0);
      cs_n_r        <= 1'b1;
      sck_r         <= 1'b0;
      mosi_r        <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      rvalid_r      <= 1'b0;
      rdata_r       <= 8'h00;
    end else begin
      done_r   <= 1'b0;
      rvalid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd.cmd_type[4]) begin
            state_r       <= CS_SETUP;
            busy_r        <= 1'b1;
            frame_valid_r <= dec_valid_s;
            tx_sr_r       <= dec_frame_s;
            tx_bits_r     <= dec_tx_bits_s;
            total_bits_r  <= dec_total_s;
            bit_cnt_r     <= 7'd0;
            rx_sr_r       <= 7'd0;
          end
        end
        CS_SETUP: begin
          if (frame_valid_r) begin
            cs_n_r  <= 1'b0;
            sck_r   <= 1'b0;
            mosi_r  <= tx_sr_r[63];
            state_r <= SHIFT;
          end else begin
            // Unknown command: finish immediately without touching the bus
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (!sck_r) begin
            if (bit_cnt_r == total_bits_r) begin
              cs_n_r    <= 1'b1;
              mosi_r    <= 1'b0;
              done_r    <= 1'b1;
              gap_cnt_r <= GAP_LOAD;
              state_r   <= CS_HOLD;
            end else begin
              sck_r <= 1'b1;
            end
          end else begin
            sck_r     <= 1'b0;
            bit_cnt_r <= bit_cnt_r + 7'd1;
            tx_sr_r   <= {tx_sr_r[62:0], 1'b0};
            mosi_r    <= tx_sr_r[62];
            // Read bits trail the transmit bits, so byte boundaries stay 8-aligned
            if (bit_cnt_r >= tx_bits_r) begin
              rx_sr_r <= {rx_sr_r[5:0], flash_miso};
              if (bit_cnt_r[2:0] == 3'd7) begin
                rdata_r  <= {rx_sr_r, flash_miso};
                rvalid_r <= 1'b1;
              end
            end
          end
        end
        CS_HOLD, GAP: begin
          if (gap_cnt_r == GAP_W'(0)) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - GAP_W'(1);
            state_r   <= GAP;
          end
        end
        default: begin
          state_r <= IDLE;
          cs_n_r  <= 1'b1;
          sck_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign flash_cs_n     = cs_n_r;
  assign flash_sck      = sck_r;
  assign flash_mosi     = mosi_r;
  assign cmd.cmd_busy   = busy_r;
  assign cmd.cmd_done   = done_r;
  assign cmd.cmd_rdata  = rdata_r;
  assign cmd.cmd_rvalid = rvalid_r;

endmodule

// File: tb/tb_spi_flash_cmd_engine.sv
// Directed bench for spi_flash_cmd_engine: frame timing, MOSI content, read bytes,
// request blocking while busy, mid-frame reset and unknown command handling.
module tb_spi_flash_cmd_engine;
  logic spi_clk = 1'b0;
  logic spi_resetn = 1'b0;
  logic flash_miso = 1'b0;
  logic flash_cs_n, flash_sck, flash_mosi;

  spi_flash_cmd_engine_if bus();

  spi_flash_cmd_engine #(.RD_BYTES(4), .WR_BYTES(4), .CS_HIGH_CYC(4)) dut (
    .spi_clk(spi_clk), .spi_resetn(spi_resetn), .cmd(bus),
    .flash_cs_n(flash_cs_n), .flash_sck(flash_sck),
    .flash_mosi(flash_mosi), .flash_miso(flash_miso)
  );

  always #5 spi_clk = ~spi_clk;

  int checks = 0;
  int passes = 0;
  int cs_first, cs_last, rises, done_cyc, done_cnt, busy_low, rv_n;
  int rv_cyc[8];
  logic [7:0] rv_dat[8];
  logic [95:0] mosi_cap;
  logic glitch;

  // Issue one request and record the frame cycle by cycle relative to the accept edge.
  task automatic run_frame(input logic [4:0] t, input logic [7:0] code, input logic [23:0] addr,
                           input logic [31:0] wd, input logic [63:0] rbytes, input int txbits);
    logic prev_sck;
    int r;
    cs_first = -1; cs_last = -1; rises = 0; done_cyc = -1; done_cnt = 0;
    busy_low = -1; rv_n = 0; mosi_cap = '0; glitch = 1'b0; prev_sck = 1'b0;
    flash_miso = 1'b0;
    @(negedge spi_clk);
    bus.cmd_type = t; bus.cmd_code = code; bus.cmd_addr = addr; bus.cmd_wdata = wd;
    @(posedge spi_clk);
    #1 bus.cmd_type = 5'd0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge spi_clk);
      #1;
      if (!flash_cs_n) begin
        if (cs_first < 0) cs_first = cyc;
        cs_last = cyc;
      end
      if (flash_cs_n && flash_sck) glitch = 1'b1;
      if (flash_sck && !prev_sck) begin
        rises++;
        mosi_cap = {mosi_cap[94:0], flash_mosi};
        r = rises - 1 - txbits;
        if (r >= 0 && r < 64) flash_miso = rbytes[63 - r];
      end
      prev_sck = flash_sck;
      if (bus.cmd_rvalid && rv_n < 8) begin
        rv_cyc[rv_n] = cyc; rv_dat[rv_n] = bus.cmd_rdata; rv_n++;
      end
      if (bus.cmd_done) begin done_cnt++; done_cyc = cyc; end
      if (!bus.cmd_busy) begin busy_low = cyc; break; end
    end
    if (busy_low < 0) begin
      checks++;
      $display("FAIL frame_timeout type=%b busy never dropped within 400 cycles", t);
    end
  endtask

  task automatic test_reset;
    bus.cmd_type = 5'd0; bus.cmd_code = 8'h00; bus.cmd_addr = 24'h0; bus.cmd_wdata = 32'h0;
    spi_resetn = 1'b0;
    repeat (3) @(posedge spi_clk);
    #1;
    checks++;
    if ({flash_cs_n, flash_sck, flash_mosi} !== 3'b100)
      $display("FAIL reset_pins got cs/sck/mosi=%b want 100", {flash_cs_n, flash_sck, flash_mosi});
    else passes++;
    checks++;
    if ({bus.cmd_busy, bus.cmd_done, bus.cmd_rvalid, bus.cmd_rdata} !== 11'd0)
      $display("FAIL reset_cmd got busy/done/rvalid/rdata=%b want 0",
               {bus.cmd_busy, bus.cmd_done, bus.cmd_rvalid, bus.cmd_rdata});
    else passes++;
    spi_resetn = 1'b1;
    @(posedge spi_clk);
  endtask

  task automatic test_wr_en;
    run_frame(5'b10001, 8'h06, 24'h0, 32'h0, 64'h0, 8);
    checks++;
    if (cs_first !== 1 || cs_last !== 17)
      $display("FAIL wr_en_cs got %0d..%0d want 1..17", cs_first, cs_last);
    else passes++;
    checks++;
    if (rises !== 8 || mosi_cap[7:0] !== 8'h06)
      $display("FAIL wr_en_mosi got %0d pulses data %h want 8 pulses 06", rises, mosi_cap[7:0]);
    else passes++;
    checks++;
    if (done_cyc !== 18 || done_cnt !== 1)
      $display("FAIL wr_en_done got cycle %0d count %0d want 18 count 1", done_cyc, done_cnt);
    else passes++;
    checks++;
    if (busy_low !== 22) $display("FAIL wr_en_busy got %0d want 22", busy_low);
    else passes++;
    checks++;
    if (glitch !== 1'b0 || rv_n !== 0)
      $display("FAIL wr_en_misc got glitch %b rvalid %0d want 0 0", glitch, rv_n);
    else passes++;
  endtask

  task automatic test_rd_id;
    int exp_c[3] = '{33, 49, 65};
    logic [7:0] exp_d[3] = '{8'hEF, 8'h40, 8'h18};
    run_frame(5'b10000, 8'h9F, 24'h0, 32'h0, 64'hEF4018_0000000000, 8);
    checks++;
    if (rv_n !== 3) $display("FAIL rd_id_count got %0d want 3", rv_n);
    else passes++;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (rv_cyc[j] !== exp_c[j] || rv_dat[j] !== exp_d[j])
        $display("FAIL rd_id_byte%0d got cycle %0d data %h want %0d %h",
                 j, rv_cyc[j], rv_dat[j], exp_c[j], exp_d[j]);
      else passes++;
    end
    checks++;
    if (done_cyc !== 66 || mosi_cap[31:0] !== 32'h9F000000)
      $display("FAIL rd_id_done got %0d mosi %h want 66 9f000000", done_cyc, mosi_cap[31:0]);
    else passes++;
  endtask

  task automatic test_rd_data;
    int exp_c[4] = '{81, 97, 113, 129};
    logic [7:0] exp_d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(5'b10111, 8'h03, 24'h012345, 32'h0, 64'h11223344_00000000, 32);
    checks++;
    if (rises !== 64 || mosi_cap[63:0] !== 64'h03012345_00000000)
      $display("FAIL rd_data_mosi got %0d pulses %h want 64 0301234500000000", rises, mosi_cap[63:0]);
    else passes++;
    checks++;
    if (rv_n !== 4) $display("FAIL rd_data_count got %0d want 4", rv_n);
    else passes++;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (rv_cyc[j] !== exp_c[j] || rv_dat[j] !== exp_d[j])
        $display("FAIL rd_data_byte%0d got cycle %0d data %h want %0d %h",
                 j, rv_cyc[j], rv_dat[j], exp_c[j], exp_d[j]);
      else passes++;
    end
    checks++;
    if (done_cyc !== 130 || cs_last !== 129)
      $display("FAIL rd_data_done got done %0d cs_last %0d want 130 129", done_cyc, cs_last);
    else passes++;
  endtask

  task automatic test_prog_page;
    run_frame(5'b10101, 8'h02, 24'h000100, 32'hA1B2C3D4, 64'h0, 64);
    checks++;
    if (rises !== 64 || mosi_cap[63:0] !== 64'h02000100_D4C3B2A1)
      $display("FAIL prog_mosi got %0d pulses %h want 64 02000100d4c3b2a1", rises, mosi_cap[63:0]);
    else passes++;
    checks++;
    if (rv_n !== 0 || done_cyc !== 130 || busy_low !== 134)
      $display("FAIL prog_timing got rvalid %0d done %0d busy_low %0d want 0 130 134",
               rv_n, done_cyc, busy_low);
    else passes++;
  endtask

  task automatic test_unknown;
    run_frame(5'b11000, 8'hAA, 24'h0, 32'h0, 64'h0, 8);
    checks++;
    if (done_cyc !== 1 || busy_low !== 1 || cs_first !== -1)
      $display("FAIL unknown got done %0d busy_low %0d cs_first %0d want 1 1 -1",
               done_cyc, busy_low, cs_first);
    else passes++;
  endtask

  task automatic test_back_to_back;
    int falls[4];
    int nf = 0, nd = 0, nr = 0;
    int dn[4];
    int rvc = -1;
    logic [7:0] rvd = 8'h00;
    logic prev_cs = 1'b1;
    logic b22 = 1'bx, b23 = 1'bx;
    flash_miso = 1'b1;
    @(negedge spi_clk);
    bus.cmd_type = 5'b10001; bus.cmd_code = 8'h06;
    @(posedge spi_clk);
    #1 bus.cmd_type = 5'b10011; bus.cmd_code = 8'h05;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge spi_clk);
      #1;
      if (prev_cs && !flash_cs_n && nf < 4) begin falls[nf] = cyc; nf++; end
      prev_cs = flash_cs_n;
      if (bus.cmd_done && nd < 4) begin dn[nd] = cyc; nd++; end
      if (bus.cmd_rvalid) begin rvc = cyc; rvd = bus.cmd_rdata; nr++; end
      if (cyc == 22) b22 = bus.cmd_busy;
      if (cyc == 23) begin b23 = bus.cmd_busy; bus.cmd_type = 5'd0; end
    end
    flash_miso = 1'b0;
    checks++;
    if (nf !== 2 || falls[0] !== 1 || falls[1] !== 24)
      $display("FAIL b2b_frames got %0d frames (%0d,%0d) want 2 (1,24)", nf, falls[0], falls[1]);
    else passes++;
    checks++;
    if (b22 !== 1'b0 || b23 !== 1'b1)
      $display("FAIL b2b_busy got c22=%b c23=%b want 0 1", b22, b23);
    else passes++;
    checks++;
    if (nd !== 2 || dn[0] !== 18 || dn[1] !== 57)
      $display("FAIL b2b_done got %0d pulses (%0d,%0d) want 2 (18,57)", nd, dn[0], dn[1]);
    else passes++;
    checks++;
    if (nr !== 1 || rvc !== 56 || rvd !== 8'hFF)
      $display("FAIL b2b_status got %0d bytes cycle %0d data %h want 1 56 ff", nr, rvc, rvd);
    else passes++;
  endtask

  task automatic test_reset_mid_frame;
    logic bad = 1'b0;
    @(negedge spi_clk);
    bus.cmd_type = 5'b10111; bus.cmd_code = 8'h03; bus.cmd_addr = 24'h012345;
    @(posedge spi_clk);
    #1 bus.cmd_type = 5'd0;
    for (int cyc = 1; cyc <= 39; cyc++) begin
      @(posedge spi_clk);
      #1;
    end
    spi_resetn = 1'b0;
    @(posedge spi_clk);
    #1;
    checks++;
    if ({flash_cs_n, flash_sck, bus.cmd_busy, bus.cmd_done} !== 4'b1000)
      $display("FAIL midreset_state got cs/sck/busy/done=%b want 1000",
               {flash_cs_n, flash_sck, bus.cmd_busy, bus.cmd_done});
    else passes++;
    @(posedge spi_clk);
    #1 spi_resetn = 1'b1;
    repeat (3) begin
      @(posedge spi_clk);
      #1;
      if (bus.cmd_done || !flash_cs_n || bus.cmd_busy) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) $display("FAIL midreset_quiet got activity %b want 0", bad);
    else passes++;
    run_frame(5'b10000, 8'h9F, 24'h0, 32'h0, 64'hC22017_0000000000, 8);
    checks++;
    if (rv_n !== 3 || rv_dat[0] !== 8'hC2 || rv_dat[1] !== 8'h20 || rv_dat[2] !== 8'h17 || done_cyc !== 66)
      $display("FAIL midreset_rdid got %0d bytes %h %h %h done %0d want 3 c2 20 17 66",
               rv_n, rv_dat[0], rv_dat[1], rv_dat[2], done_cyc);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_wr_en();
    test_rd_id();
    test_rd_data();
    test_prog_page();
    test_back_to_back();
    test_reset_mid_frame();
    test_unknown();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
